// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-master AHB-Lite arbiter:
// FSM states, HTRANS encodings and the pending-slot control bundle.
package ahb_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef struct packed {
      logic [2:0] hsize;
      logic [3:0] hprot;
      logic       hwrite;
   } slot_ctrl_t;

endpackage

// File: rtl/ahb_arb_req_slot.sv
// One-deep pending request slot for a single master.
// A capture on the completion edge wins over the clear.
module ahb_arb_req_slot
   import ahb_arb_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    i_htrans,
   input  logic [AW-1:0] i_haddr,
   input  slot_ctrl_t    i_ctrl,
   input  logic          i_hready,
   input  logic          i_clr,
   output logic          o_pend,
   output logic [AW-1:0] o_haddr,
   output slot_ctrl_t    o_ctrl
);

   logic w_cap;

   assign w_cap = i_hready &&
                  (i_htrans == HTRANS_NONSEQ || i_htrans == HTRANS_SEQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_pend  <= 1'b0;
         o_haddr <= '0;
         o_ctrl  <= '0;
      end else if (w_cap) begin
         o_pend  <= 1'b1;
         o_haddr <= i_haddr;
         o_ctrl  <= i_ctrl;
      end else if (i_clr) begin
         o_pend  <= 1'b0;
      end
   end

endmodule

// File: rtl/ahb_master_arb2.sv
// Two-master (imem/dmem) to one-slave AHB-Lite arbiter, SINGLE transfers,
// non-pipelined: address phase from the pending slot, then one data phase.
module ahb_master_arb2
   import ahb_arb_pkg::*;
#(
   parameter int AHB_WIDTH = 32,
   parameter int DMEM_PRIO = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           imem_htrans,
   input  logic [AHB_WIDTH-1:0] imem_haddr,
   input  logic [2:0]           imem_hsize,
   input  logic [3:0]           imem_hprot,
   output logic                 imem_hready,
   output logic [AHB_WIDTH-1:0] imem_hrdata,
   output logic                 imem_hresp,
   input  logic [1:0]           dmem_htrans,
   input  logic [AHB_WIDTH-1:0] dmem_haddr,
   input  logic [2:0]           dmem_hsize,
   input  logic [3:0]           dmem_hprot,
   input  logic                 dmem_hwrite,
   input  logic [AHB_WIDTH-1:0] dmem_hwdata,
   output logic                 dmem_hready,
   output logic [AHB_WIDTH-1:0] dmem_hrdata,
   output logic                 dmem_hresp,
   output logic [1:0]           s_htrans,
   output logic [AHB_WIDTH-1:0] s_haddr,
   output logic [2:0]           s_hsize,
   output logic [3:0]           s_hprot,
   output logic                 s_hwrite,
   output logic [AHB_WIDTH-1:0] s_hwdata,
   input  logic                 s_hready,
   input  logic [AHB_WIDTH-1:0] s_hrdata,
   input  logic                 s_hresp
);

   state_t r_state;
   logic   r_own;
   logic   r_last;

   logic                 w_ipend, w_dpend;
   logic [AHB_WIDTH-1:0] w_iaddr, w_daddr;
   slot_ctrl_t           w_ictrl, w_dctrl;
   slot_ctrl_t           w_ictrl_in, w_dctrl_in;
   logic                 w_data, w_own_i, w_own_d;
   logic                 w_clr_i, w_clr_d, w_sel_d, w_any;

   assign w_ictrl_in = '{hsize: imem_hsize, hprot: imem_hprot, hwrite: 1'b0};
   assign w_dctrl_in = '{hsize: dmem_hsize, hprot: dmem_hprot, hwrite: dmem_hwrite};

   assign w_data  = (r_state == ST_DATA);
   assign w_own_i = w_data && !r_own;
   assign w_own_d = w_data && r_own;
   assign w_clr_i = w_own_i && s_hready;
   assign w_clr_d = w_own_d && s_hready;
   assign w_any   = w_ipend || w_dpend;

   // r_last: 0 = imem granted last, 1 = dmem granted last
   assign w_sel_d = w_dpend && (!w_ipend || DMEM_PRIO != 0 || !r_last);

   assign imem_hready = w_ipend ? (w_own_i && s_hready) : 1'b1;
   assign dmem_hready = w_dpend ? (w_own_d && s_hready) : 1'b1;
   assign imem_hrdata = w_own_i ? s_hrdata : '0;
   assign dmem_hrdata = w_own_d ? s_hrdata : '0;
   assign imem_hresp  = w_own_i && s_hresp;
   assign dmem_hresp  = w_own_d && s_hresp;

   ahb_arb_req_slot #(.AW(AHB_WIDTH)) u_imem_slot (
      .clk      (clk),
      .rst      (rst),
      .i_htrans (imem_htrans),
      .i_haddr  (imem_haddr),
      .i_ctrl   (w_ictrl_in),
      .i_hready (imem_hready),
      .i_clr    (w_clr_i),
      .o_pend   (w_ipend),
      .o_haddr  (w_iaddr),
      .o_ctrl   (w_ictrl)
   );

   ahb_arb_req_slot #(.AW(AHB_WIDTH)) u_dmem_slot (
      .clk      (clk),
      .rst      (rst),
      .i_htrans (dmem_htrans),
      .i_haddr  (dmem_haddr),
      .i_ctrl   (w_dctrl_in),
      .i_hready (dmem_hready),
      .i_clr    (w_clr_d),
      .o_pend   (w_dpend),
      .o_haddr  (w_daddr),
      .o_ctrl   (w_dctrl)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_own   <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_any && s_hready) begin
                  r_state <= ST_DATA;
                  r_own   <= w_sel_d;
               end
            end
            ST_DATA: begin
               if (s_hready) begin
                  r_state <= ST_IDLE;
                  r_last  <= r_own;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      s_htrans = HTRANS_IDLE;
      s_haddr  = '0;
      s_hsize  = '0;
      s_hprot  = '0;
      s_hwrite = 1'b0;
      s_hwdata = '0;
      if (!w_data && w_any) begin
         s_htrans = HTRANS_NONSEQ;
         s_haddr  = w_sel_d ? w_daddr : w_iaddr;
         s_hsize  = w_sel_d ? w_dctrl.hsize : w_ictrl.hsize;
         s_hprot  = w_sel_d ? w_dctrl.hprot : w_ictrl.hprot;
         s_hwrite = w_sel_d ? w_dctrl.hwrite : w_ictrl.hwrite;
      end
      if (w_data) begin
         s_hwdata = dmem_hwdata;
      end
   end

endmodule

// File: tb/tb_ahb_master_arb2.sv
// Directed self-checking bench for ahb_master_arb2 (round-robin mode).
module tb_ahb_master_arb2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  imem_htrans = 2'b00;
   logic [31:0] imem_haddr = '0;
   logic [2:0]  imem_hsize = '0;
   logic [3:0]  imem_hprot = '0;
   logic        imem_hready;
   logic [31:0] imem_hrdata;
   logic        imem_hresp;
   logic [1:0]  dmem_htrans = 2'b00;
   logic [31:0] dmem_haddr = '0;
   logic [2:0]  dmem_hsize = '0;
   logic [3:0]  dmem_hprot = '0;
   logic        dmem_hwrite = 1'b0;
   logic [31:0] dmem_hwdata = '0;
   logic        dmem_hready;
   logic [31:0] dmem_hrdata;
   logic        dmem_hresp;
   logic [1:0]  s_htrans;
   logic [31:0] s_haddr;
   logic [2:0]  s_hsize;
   logic [3:0]  s_hprot;
   logic        s_hwrite;
   logic [31:0] s_hwdata;
   logic        s_hready = 1'b1;
   logic [31:0] s_hrdata = '0;
   logic        s_hresp = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ahb_master_arb2 #(.AHB_WIDTH(32), .DMEM_PRIO(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_htrans (imem_htrans),
      .imem_haddr  (imem_haddr),
      .imem_hsize  (imem_hsize),
      .imem_hprot  (imem_hprot),
      .imem_hready (imem_hready),
      .imem_hrdata (imem_hrdata),
      .imem_hresp  (imem_hresp),
      .dmem_htrans (dmem_htrans),
      .dmem_haddr  (dmem_haddr),
      .dmem_hsize  (dmem_hsize),
      .dmem_hprot  (dmem_hprot),
      .dmem_hwrite (dmem_hwrite),
      .dmem_hwdata (dmem_hwdata),
      .dmem_hready (dmem_hready),
      .dmem_hrdata (dmem_hrdata),
      .dmem_hresp  (dmem_hresp),
      .s_htrans    (s_htrans),
      .s_haddr     (s_haddr),
      .s_hsize     (s_hsize),
      .s_hprot     (s_hprot),
      .s_hwrite    (s_hwrite),
      .s_hwdata    (s_hwdata),
      .s_hready    (s_hready),
      .s_hrdata    (s_hrdata),
      .s_hresp     (s_hresp)
   );

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({imem_hready, dmem_hready} !== 2'b11) begin
         n_fail++;
         $display("FAIL rst_hready: got %b want 11", {imem_hready, dmem_hready});
      end
      n_chk++;
      if ({imem_hresp, dmem_hresp, imem_hrdata, dmem_hrdata} !== '0) begin
         n_fail++;
         $display("FAIL rst_resp_rdata: got %b %b %h %h want 0",
                  imem_hresp, dmem_hresp, imem_hrdata, dmem_hrdata);
      end
      n_chk++;
      if ({s_htrans, s_haddr, s_hsize, s_hprot, s_hwrite, s_hwdata} !== '0) begin
         n_fail++;
         $display("FAIL rst_slave: got htrans %b haddr %h want all 0", s_htrans, s_haddr);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      @(posedge clk); #1;
      imem_htrans = 2'b10; imem_haddr = 32'hFFFE_0010;
      imem_hsize = 3'd2; imem_hprot = 4'h3;
      s_hready = 1'b1; s_hrdata = 32'h1234_5678;
      @(posedge clk); #1;
      imem_htrans = 2'b00;
      @(negedge clk);
      n_chk++;
      if ({s_htrans, s_haddr} !== {2'b10, 32'hFFFE_0010}) begin
         n_fail++;
         $display("FAIL rd_addr_phase: got %b %h want 10 fffe0010", s_htrans, s_haddr);
      end
      n_chk++;
      if ({s_hsize, s_hprot, s_hwrite} !== {3'd2, 4'h3, 1'b0}) begin
         n_fail++;
         $display("FAIL rd_ctrl: got %h %h %b want 2 3 0", s_hsize, s_hprot, s_hwrite);
      end
      n_chk++;
      if (imem_hready !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_wait: got imem_hready %b want 0", imem_hready);
      end
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({imem_hready, imem_hrdata} !== {1'b1, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL rd_data: got %b %h want 1 12345678", imem_hready, imem_hrdata);
      end
      n_chk++;
      if ({s_htrans, dmem_hrdata} !== '0) begin
         n_fail++;
         $display("FAIL rd_data_phase: got htrans %b dmem_hrdata %h want 0 0", s_htrans, dmem_hrdata);
      end
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({s_htrans, imem_hready} !== 3'b001) begin
         n_fail++;
         $display("FAIL rd_done: got htrans %b hready %b want 00 1", s_htrans, imem_hready);
      end
   endtask

   task automatic test_tie_round_robin();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      s_hready = 1'b1; s_hrdata = 32'hCAFE_0001;
      @(posedge clk); #1;
      imem_htrans = 2'b10; imem_haddr = 32'h0000_1000;
      dmem_htrans = 2'b10; dmem_haddr = 32'h0000_2000; dmem_hwrite = 1'b0;
      @(posedge clk); #1;
      imem_htrans = 2'b00; dmem_htrans = 2'b00;
      @(negedge clk);
      n_chk++;
      if ({s_htrans, s_haddr} !== {2'b10, 32'h0000_2000}) begin
         n_fail++;
         $display("FAIL tie1_dmem_first: got %b %h want 10 00002000", s_htrans, s_haddr);
      end
      n_chk++;
      if ({imem_hready, dmem_hready} !== 2'b00) begin
         n_fail++;
         $display("FAIL tie1_wait: got %b want 00", {imem_hready, dmem_hready});
      end
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({dmem_hready, dmem_hrdata, imem_hready, imem_hrdata} !== {1'b1, 32'hCAFE_0001, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL tie1_dmem_data: got %b %h %b %h want 1 cafe0001 0 0",
                  dmem_hready, dmem_hrdata, imem_hready, imem_hrdata);
      end
      dmem_htrans = 2'b10; dmem_haddr = 32'h0000_3000;
      @(posedge clk); #1;
      dmem_htrans = 2'b00;
      @(negedge clk);
      n_chk++;
      if ({s_htrans, s_haddr} !== {2'b10, 32'h0000_1000}) begin
         n_fail++;
         $display("FAIL tie2_imem_first: got %b %h want 10 00001000", s_htrans, s_haddr);
      end
      n_chk++;
      if (dmem_hready !== 1'b0) begin
         n_fail++;
         $display("FAIL tie2_dmem_kept: got dmem_hready %b want 0", dmem_hready);
      end
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({imem_hready, dmem_hready} !== 2'b10) begin
         n_fail++;
         $display("FAIL tie2_imem_data: got %b want 10", {imem_hready, dmem_hready});
      end
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({s_htrans, s_haddr} !== {2'b10, 32'h0000_3000}) begin
         n_fail++;
         $display("FAIL tie2_dmem_second: got %b %h want 10 00003000", s_htrans, s_haddr);
      end
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (dmem_hready !== 1'b1) begin
         n_fail++;
         $display("FAIL tie2_dmem_data: got %b want 1", dmem_hready);
      end
      @(posedge clk);
   endtask

   task automatic test_write_wait();
      @(posedge clk); #1;
      dmem_htrans = 2'b10; dmem_haddr = 32'hFFDF_0000; dmem_hwrite = 1'b1;
      s_hready = 1'b1;
      @(posedge clk); #1;
      dmem_htrans = 2'b00; dmem_hwdata = 32'h0000_00A5;
      @(negedge clk);
      n_chk++;
      if ({s_htrans, s_haddr, s_hwrite} !== {2'b10, 32'hFFDF_0000, 1'b1}) begin
         n_fail++;
         $display("FAIL wr_addr_phase: got %b %h %b want 10 ffdf0000 1", s_htrans, s_haddr, s_hwrite);
      end
      @(posedge clk); #1;
      s_hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if ({s_hwdata, dmem_hready} !== {32'h0000_00A5, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_stall%0d: got %h %b want a5 0", i, s_hwdata, dmem_hready);
         end
         @(posedge clk);
      end
      #1;
      s_hready = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({s_hwdata, dmem_hready} !== {32'h0000_00A5, 1'b1}) begin
         n_fail++;
         $display("FAIL wr_done: got %h %b want a5 1", s_hwdata, dmem_hready);
      end
      @(posedge clk); #1;
      dmem_hwrite = 1'b0; dmem_hwdata = '0;
   endtask

   task automatic test_error();
      @(posedge clk); #1;
      dmem_htrans = 2'b10; dmem_haddr = 32'hFFDF_0004;
      @(posedge clk); #1;
      dmem_htrans = 2'b00;
      @(posedge clk); #1;
      s_hready = 1'b0; s_hresp = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({dmem_hresp, dmem_hready, imem_hresp} !== 3'b100) begin
         n_fail++;
         $display("FAIL err_cycle1: got %b want 100", {dmem_hresp, dmem_hready, imem_hresp});
      end
      @(posedge clk); #1;
      s_hready = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({dmem_hresp, dmem_hready, imem_hresp} !== 3'b110) begin
         n_fail++;
         $display("FAIL err_cycle2: got %b want 110", {dmem_hresp, dmem_hready, imem_hresp});
      end
      @(posedge clk); #1;
      s_hresp = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({dmem_hresp, dmem_hready, s_htrans} !== 4'b0100) begin
         n_fail++;
         $display("FAIL err_after: got %b want 0100", {dmem_hresp, dmem_hready, s_htrans});
      end
   endtask

   task automatic test_back_to_back();
      s_hrdata = 32'h0BAD_F00D;
      @(posedge clk); #1;
      imem_htrans = 2'b10; imem_haddr = 32'hFFFE_0020;
      @(posedge clk); #1;
      imem_htrans = 2'b00;
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (imem_hready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_done: got %b want 1", imem_hready);
      end
      imem_htrans = 2'b10; imem_haddr = 32'hFFFE_0024;
      @(posedge clk); #1;
      imem_htrans = 2'b00;
      @(negedge clk);
      n_chk++;
      if ({s_htrans, s_haddr, imem_hready} !== {2'b10, 32'hFFFE_0024, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_second_addr: got %b %h %b want 10 fffe0024 0", s_htrans, s_haddr, imem_hready);
      end
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({imem_hready, imem_hrdata} !== {1'b1, 32'h0BAD_F00D}) begin
         n_fail++;
         $display("FAIL b2b_second_data: got %b %h want 1 0badf00d", imem_hready, imem_hrdata);
      end
      @(posedge clk);
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      imem_htrans = 2'b10; imem_haddr = 32'h0000_4000;
      dmem_htrans = 2'b10; dmem_haddr = 32'h0000_5000;
      @(posedge clk); #1;
      imem_htrans = 2'b00; dmem_htrans = 2'b00;
      @(posedge clk); #1;
      s_hready = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({imem_hready, dmem_hready, s_htrans} !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_stalled: got %b want 0000", {imem_hready, dmem_hready, s_htrans});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({imem_hready, dmem_hready, s_htrans} !== 4'b1100) begin
         n_fail++;
         $display("FAIL mid_rst: got %b want 1100", {imem_hready, dmem_hready, s_htrans});
      end
      @(negedge clk);
      rst = 1'b0; s_hready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({imem_hready, dmem_hready, s_htrans} !== 4'b1100) begin
         n_fail++;
         $display("FAIL mid_no_replay: got %b want 1100", {imem_hready, dmem_hready, s_htrans});
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie_round_robin();
      test_write_wait();
      test_error();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_master_arb2.md
AHB_MASTER_ARB2 -- requirements
Module: ahb_master_arb2

Interface
REQ-001 The block SHALL have parameter AHB_WIDTH, default 32, which sets the address and data width.
REQ-002 The block SHALL have parameter DMEM_PRIO, default 0: 0 = round-robin, 1 = dmem always wins a tie.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- imem_htrans  in  2  imem master transfer type.
- imem_haddr  in  AHB_WIDTH  imem address.
- imem_hsize  in  3  imem size.
- imem_hprot  in  4  imem protection.
- imem_hready  out  1  imem ready.
- imem_hrdata  out  AHB_WIDTH  imem read data.
- imem_hresp  out  1  imem response.
- dmem_htrans  in  2  dmem transfer type.
- dmem_haddr  in  AHB_WIDTH  dmem address.
- dmem_hsize  in  3  dmem size.
- dmem_hprot  in  4  dmem protection.
- dmem_hwrite  in  1  dmem write.
- dmem_hwdata  in  AHB_WIDTH  dmem write data.
- dmem_hready  out  1  dmem ready.
- dmem_hrdata  out  AHB_WIDTH  dmem read data.
- dmem_hresp  out  1  dmem response.
- s_htrans, s_haddr, s_hsize, s_hprot, s_hwrite, s_hwdata  out  2/AHB_WIDTH/3/4/1/AHB_WIDTH  shared slave address/control/write data.
- s_hready  in  1  slave ready.
- s_hrdata  in  AHB_WIDTH  slave read data.
- s_hresp  in  1  slave response.

Function
REQ-005 The block SHALL capture a master request into that master's pending slot on any rising edge where its htrans[1]=1 (NONSEQ or SEQ) and its hready=1; the slot holds haddr, hsize, hprot and hwrite (imem hwrite=0).
REQ-006 The block SHALL ignore IDLE and BUSY transfers; hburst is not an input, and every transfer is treated as SINGLE.
REQ-007 A master's hready SHALL be 0 while its slot is pending and not yet completed, and 1 otherwise.
REQ-008 The block SHALL implement an FSM with states IDLE and DATA; the reset state SHALL be IDLE.
REQ-009 In IDLE with at least one slot pending, the block SHALL drive s_htrans=NONSEQ with the selected slot's fields; on an edge with s_hready=1 it SHALL latch the owner and enter DATA.
REQ-010 In IDLE with no slot pending, the block SHALL drive s_htrans=IDLE and all other slave outputs to 0.
REQ-011 In DATA, the block SHALL drive s_htrans=IDLE and forward s_hwdata from the live dmem_hwdata (dmem holds it stable while stalled); the owner's hrdata SHALL equal s_hrdata.
REQ-012 In DATA, the owner's hresp SHALL equal s_hresp and its hready SHALL equal s_hready, so a two-cycle ERROR response passes through intact.
REQ-013 In DATA, on an edge with s_hready=1, the block SHALL clear the owner's slot, update last_grant and return to IDLE.
REQ-014 For every non-owner, hresp SHALL be 0 and hrdata SHALL be 0.
REQ-015 Arbitration with both slots pending:
- DMEM_PRIO=1: dmem wins.
- DMEM_PRIO=0: the master that is not last_grant wins.
- A single pending slot always wins.
REQ-016 When a master issues a new request on its own completion edge, the slot set SHALL take precedence over the clear, so the transfer runs back-to-back with no loss.
REQ-017 Latency from acceptance edge N, with an idle bus and a zero-wait slave: s_htrans=NONSEQ in cycle N+1, and master hready=1 with data in cycle N+2 (one wait state).
REQ-018 In round-robin mode, a pending master SHALL wait at most one foreign transfer.

Reset
REQ-019 While rst=1, the block SHALL clear both slots, set the FSM to IDLE and set last_grant=imem (dmem wins the first tie).
REQ-020 Output values while rst=1 SHALL be: imem_hready=1, dmem_hready=1, all hresp=0, all hrdata=0, s_htrans=IDLE, all other s_* outputs=0.
REQ-021 Reset asserted mid-transfer SHALL drop the in-flight transfer and both pending requests without replay.

Structure
REQ-022 Package ahb_arb_pkg SHALL hold the FSM state enum, the HTRANS constants (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11) and the slot struct type.
REQ-023 Sub-module ahb_arb_req_slot SHALL be instantiated once per master and implement capture/clear/pending.

Verification
REQ-024 Single read: imem NONSEQ 0xFFFE_0010 with a zero-wait slave returning 0x1234_5678 -> s_htrans NONSEQ in cycle N+1, imem_hready=1 and imem_hrdata=0x1234_5678 in cycle N+2.
REQ-025 Simultaneous requests after reset: imem and dmem both request on the same edge -> dmem is served first, imem second; next tie -> imem first.
REQ-026 Write with wait states: dmem write 0xFFDF_0000 data 0xA5, slave s_hready low for 3 cycles -> s_hwdata=0xA5 held throughout, dmem_hready low until the slave completes.
REQ-027 Error pass-through: slave ERROR (hresp=1 with hready=0, then hresp=1 with hready=1) on dmem -> dmem_hresp mirrors both cycles; imem_hresp stays 0.
REQ-028 Back-to-back and reset: imem issues a new request on its completion edge -> served without loss; rst=1 in DATA -> FSM goes to IDLE, both hready=1, s_htrans=IDLE.
